// File: rtl/trig_detect_pkg.sv
// Shared types and constants for the trigger qualifier: FSM state encoding,
// edge_sel condition codes and the start-condition helper.
package trig_detect_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    FILTER  = 2'd2,
    HOLDOFF = 2'd3
  } state_e;

  localparam logic [1:0] EDGE_RISE  = 2'b00;
  localparam logic [1:0] EDGE_FALL  = 2'b01;
  localparam logic [1:0] EDGE_BOTH  = 2'b10;
  localparam logic [1:0] LEVEL_HIGH = 2'b11;

  // True when a valid sample starts a qualification run in the given mode;
  // prev is the last valid sample seen while armed.
  function automatic logic start_hit(input logic [1:0] mode,
                                     input logic       smp,
                                     input logic       vld,
                                     input logic       prev);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISE:  hit = smp & ~prev;
      EDGE_FALL:  hit = ~smp & prev;
      EDGE_BOTH:  hit = smp ^ prev;
      LEVEL_HIGH: hit = smp;
      default:    hit = 1'b0;
    endcase
    return vld & hit;
  endfunction

endpackage

// File: rtl/trig_detect_qualify.sv
// Down-counter shared by the FILTER and HOLDOFF phases of trig_detect:
// synchronous load (priority), decrement, and a zero flag.
module trig_qualify #(
  parameter int W = 16
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/trig_detect.sv
// Trigger qualifier: edge/level detection with glitch filter and holdoff.
// Define TRIG_COUNT_EN to build the trigger counter and sticky wrap flag.
module trig_detect
  import trig_detect_pkg::*;
#(
  parameter int FILTER_BITS  = 8,
  parameter int HOLDOFF_BITS = 16,
  parameter int COUNT_BITS   = 32
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    arm_i,
  input  logic [1:0]              edge_sel_i,
  input  logic [FILTER_BITS-1:0]  filter_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  input  logic                    in_i,
  input  logic                    in_valid_i,
  output logic                    trig_o,
  output logic                    armed_o,
  output logic                    busy_o,
  output logic [COUNT_BITS-1:0]   trig_count_o,
  output logic                    count_ovf_o
);

  localparam int QW = (FILTER_BITS > HOLDOFF_BITS) ? FILTER_BITS : HOLDOFF_BITS;

  state_e                  state_q, state_d;
  logic                    trig_q, trig_d;
  logic                    prev_q, prev_d;
  logic                    tgt_q, tgt_d;
  logic [1:0]              mode_q, mode_d;
  logic [FILTER_BITS-1:0]  filt_q, filt_d;
  logic [HOLDOFF_BITS-1:0] hold_q, hold_d;

  logic          q_load, q_dec, q_zero;
  logic [QW-1:0] q_val;
  logic          fire, hit, good;

  trig_qualify #(.W(QW)) u_qual (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .load_i     (q_load),
    .load_val_i (q_val),
    .dec_i      (q_dec),
    .zero_o     (q_zero)
  );

  assign hit  = start_hit(mode_q, in_i, in_valid_i, prev_q);
  assign good = in_valid_i && (in_i == tgt_q);

  // Counter values are stored minus one so that FILTER lasts F cycles and
  // HOLDOFF lasts H cycles including the trigger cycle.
  always_comb begin
    state_d = state_q;
    trig_d  = 1'b0;
    prev_d  = prev_q;
    tgt_d   = tgt_q;
    mode_d  = mode_q;
    filt_d  = filt_q;
    hold_d  = hold_q;
    q_load  = 1'b0;
    q_dec   = 1'b0;
    q_val   = '0;
    fire    = 1'b0;

    case (state_q)
      IDLE: begin
        prev_d = in_i & in_valid_i;
        if (arm_i) begin
          state_d = ARMED;
          mode_d  = edge_sel_i;
          filt_d  = filter_i;
          hold_d  = holdoff_i;
        end
      end
      ARMED: begin
        if (in_valid_i) prev_d = in_i;
        if (hit) begin
          tgt_d = (mode_q == LEVEL_HIGH) ? 1'b1 : in_i;
          if (filt_q == '0) begin
            fire = 1'b1;
          end else begin
            state_d = FILTER;
            q_load  = 1'b1;
            q_val   = QW'(filt_q) - QW'(1);
          end
        end
      end
      FILTER: begin
        if (in_valid_i) prev_d = in_i;
        if (!good) begin
          state_d = ARMED;
        end else if (q_zero) begin
          fire = 1'b1;
        end else begin
          q_dec = 1'b1;
        end
      end
      HOLDOFF: begin
        if (in_valid_i) prev_d = in_i;
        if (q_zero) begin
          state_d = ARMED;
        end else begin
          q_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fire) begin
      trig_d = 1'b1;
      if (hold_q == '0) begin
        state_d = ARMED;
      end else begin
        state_d = HOLDOFF;
        q_load  = 1'b1;
        q_val   = QW'(hold_q) - QW'(1);
      end
    end

    // Disarm wins over everything, including a trigger due this cycle.
    if (!arm_i && (state_q != IDLE)) begin
      state_d = IDLE;
      trig_d  = 1'b0;
      q_load  = 1'b0;
      q_dec   = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      trig_q  <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_d;
      prev_q  <= prev_d;
    end
  end

  always_ff @(posedge clock_i) begin
    tgt_q  <= tgt_d;
    mode_q <= mode_d;
    filt_q <= filt_d;
    hold_q <= hold_d;
  end

  assign trig_o  = trig_q;
  assign armed_o = (state_q != IDLE);
  assign busy_o  = (state_q == FILTER) || (state_q == HOLDOFF);

`ifdef TRIG_COUNT_EN
  logic [COUNT_BITS-1:0] cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  cnt_clr;

  assign cnt_clr = (state_q == IDLE) && arm_i;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (cnt_clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (trig_d) begin
      cnt_d = cnt_q + COUNT_BITS'(1);
      if (cnt_q == '1) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign trig_count_o = cnt_q;
  assign count_ovf_o  = ovf_q;
`else
  assign trig_count_o = '0;
  assign count_ovf_o  = 1'b0;
`endif

endmodule

// File: tb/tb_trig_detect.sv
// Scoreboard bench for trig_detect: directed scenarios followed by random
// traffic, checked every cycle against a cycle-count reference model.
module tb_trig_detect;

  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          rst, arm, din, dv;
  logic [1:0]    es;
  logic [7:0]    flt;
  logic [15:0]   hld;
  logic          trig_o, armed_o, busy_o, count_ovf_o;
  logic [CB-1:0] trig_count_o;

  trig_detect #(.FILTER_BITS(8), .HOLDOFF_BITS(16), .COUNT_BITS(CB)) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .arm_i        (arm),
    .edge_sel_i   (es),
    .filter_i     (flt),
    .holdoff_i    (hld),
    .in_i         (din),
    .in_valid_i   (dv),
    .trig_o       (trig_o),
    .armed_o      (armed_o),
    .busy_o       (busy_o),
    .trig_count_o (trig_count_o),
    .count_ovf_o  (count_ovf_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    bit trig;
    bit armed;
    bit busy;
    int cnt;
    bit ovf;
  } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, want);
  endtask

  // Reference model: idle flag, remaining holdoff cycles, and the length of
  // the current qualification run (-1 when no run is in progress).
  bit m_idle = 1'b1;
  bit m_prev = 1'b0;
  bit m_tgt  = 1'b0;
  bit m_ovf  = 1'b0;
  int m_hold = 0;
  int m_run  = -1;
  int m_mode = 0;
  int m_F    = 0;
  int m_H    = 0;
  int m_cnt  = 0;

  task automatic model_step(output bit trig);
    bit fire, start, good;
    fire = 1'b0;
    trig = 1'b0;
    if (rst) begin
      m_idle = 1'b1; m_prev = 1'b0; m_cnt = 0; m_ovf = 1'b0; m_hold = 0; m_run = -1;
    end else if (m_idle) begin
      m_prev = din & dv;
      if (arm) begin
        m_idle = 1'b0; m_mode = int'(es); m_F = int'(flt); m_H = int'(hld);
        m_cnt = 0; m_ovf = 1'b0; m_run = -1; m_hold = 0;
      end
    end else if (!arm) begin
      m_idle = 1'b1; m_run = -1; m_hold = 0;
    end else if (m_hold > 0) begin
      if (dv) m_prev = din;
      m_hold--;
    end else if (m_run >= 0) begin
      good = dv && (din == m_tgt);
      if (dv) m_prev = din;
      if (!good) m_run = -1;
      else begin
        m_run++;
        if (m_run == m_F) fire = 1'b1;
      end
    end else begin
      case (m_mode)
        0: start = dv && din && !m_prev;
        1: start = dv && !din && m_prev;
        2: start = dv && (din != m_prev);
        default: start = dv && din;
      endcase
      if (dv) m_prev = din;
      if (start) begin
        m_tgt = (m_mode == 3) ? 1'b1 : din;
        if (m_F == 0) fire = 1'b1;
        else m_run = 0;
      end
    end
    if (fire) begin
      trig  = 1'b1;
      m_run = -1;
      m_hold = m_H;
      m_cnt = (m_cnt + 1) % (1 << CB);
      if (m_cnt == 0) m_ovf = 1'b1;
    end
  endtask

  // Inputs currently on the pins are sampled at the coming edge; the model's
  // view of the outputs after that edge is queued for the monitor.
  task automatic tick();
    exp_t e;
    bit t;
    model_step(t);
    e.due   = cyc + 1;
    e.trig  = t;
    e.armed = !m_idle;
    e.busy  = (m_hold > 0) || (m_run >= 0);
`ifdef TRIG_COUNT_EN
    e.cnt = m_cnt;
    e.ovf = m_ovf;
`else
    e.cnt = 0;
    e.ovf = 1'b0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg(input int m, input int f, input int h);
    es  = 2'(m);
    flt = 8'(f);
    hld = 16'(h);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due != cyc) chk("sched", cyc, e.due);
        chk("trig",       int'(trig_o),       int'(e.trig));
        chk("armed",      int'(armed_o),      int'(e.armed));
        chk("busy",       int'(busy_o),       int'(e.busy));
        chk("trig_count", int'(trig_count_o), e.cnt);
        chk("count_ovf",  int'(count_ovf_o),  int'(e.ovf));
      end
    end
  end

  initial begin : stim
    rst = 1'b1; arm = 1'b0; din = 1'b0; dv = 1'b1;
    cfg(0, 0, 0);
    #1;
    ticks(3);
    rst = 1'b0;
    ticks(2);

    // rising, F=0, H=0: single edge
    arm = 1'b1; ticks(4);
    din = 1'b1; ticks(3);
    din = 1'b0; ticks(2);
    arm = 1'b0; ticks(2);

    // rising, F=3: short pulse rejected, long pulse accepted
    cfg(0, 3, 0); arm = 1'b1; ticks(2);
    din = 1'b1; ticks(3);
    din = 1'b0; ticks(5);
    din = 1'b1; ticks(4);
    din = 1'b0; ticks(3);
    arm = 1'b0; ticks(2);

    // both edges, F=0, H=5: second edge swallowed by holdoff
    cfg(2, 0, 5); arm = 1'b1; ticks(2);
    din = 1'b1; ticks(3);
    din = 1'b0; ticks(4);
    din = 1'b1; ticks(7);
    arm = 1'b0; din = 1'b0; ticks(2);

    // level, F=1, H=0: periodic triggers, one invalid cycle
    cfg(3, 1, 0); arm = 1'b1; ticks(2);
    din = 1'b1; ticks(5);
    dv = 1'b0; ticks(1);
    dv = 1'b1; ticks(6);
    din = 1'b0; ticks(2);
    arm = 1'b0; ticks(2);

    // level with holdoff, continuous high
    cfg(3, 2, 3); arm = 1'b1; din = 1'b1; ticks(20);
    arm = 1'b0; din = 1'b0; ticks(2);

    // level already high at arm; then disarm in FILTER and re-arm
    cfg(0, 3, 0); din = 1'b1; arm = 1'b1; ticks(4);
    din = 1'b0; ticks(2);
    din = 1'b1; ticks(2);
    arm = 1'b0; ticks(3);
    arm = 1'b1; ticks(6);
    arm = 1'b0; din = 1'b0; ticks(2);

    // counter wrap: 16 rising edges, F=0, H=0
    cfg(0, 0, 0); arm = 1'b1; ticks(2);
    for (int i = 0; i < 16; i++) begin
      din = 1'b1; tick();
      din = 1'b0; tick();
    end
    ticks(3);
    arm = 1'b0; ticks(2);

    // random traffic, including config changes while armed
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 399) == 0);
      if (arm) arm = ($urandom_range(0, 119) != 0);
      else     arm = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0)
        cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), int'($urandom_range(0, 6)));
      if ($urandom_range(0, 2) == 0) din = ~din;
      dv = ($urandom_range(0, 7) != 0);
      tick();
    end
    rst = 1'b0; arm = 1'b0;
    ticks(3);

    @(posedge clk);
    @(posedge clk);
    chk("drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
